// File: rtl/parallel_to_serial_flow.sv
// Parallel-to-serial converter with valid/ready handshakes on both sides.
// Words are shifted out in lane-bit beats; a word can be accepted on the last-beat cycle so consecutive words leave no gap.
module parallel_to_serial_flow #(
    parameter int width     = 8,
    parameter int lane      = 1,
    parameter int msb_first = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             parallel_valid,
    input  logic [width-1:0] parallel_data,
    output logic             parallel_ready,
    output logic             serial_valid,
    output logic [lane-1:0]  serial_data,
    output logic             serial_last,
    input  logic             serial_ready,
    output logic             busy
);

    localparam int BEATS = width / lane;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [width-1:0]   shift_q, shift_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               accept;
    logic               beat_xfer;
    logic               last_beat;
    logic [lane-1:0]    head;

    assign busy         = (state_q == SEND);
    assign serial_valid = busy;
    assign last_beat    = busy && (cnt_q == LAST_CNT);
    assign serial_last  = last_beat;

    assign head        = (msb_first != 0) ? shift_q[width-1 -: lane] : shift_q[lane-1:0];
    assign serial_data = busy ? head : '0;

    // Ready is forced low while reset is held so nothing is accepted on the reset edge.
    assign parallel_ready = !rst && (!busy || (serial_ready && last_beat));
    assign accept         = parallel_valid && parallel_ready;
    assign beat_xfer      = busy && serial_ready;

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        if (accept) begin
            state_d = SEND;
            shift_d = parallel_data;
            cnt_d   = '0;
        end else if (beat_xfer) begin
            if (last_beat) begin
                state_d = IDLE;
                shift_d = '0;
                cnt_d   = '0;
            end else begin
                shift_d = (msb_first != 0) ? (shift_q << lane) : (shift_q >> lane);
                cnt_d   = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_parallel_to_serial_flow.sv
// Directed and randomized checks of parallel_to_serial_flow in four parameter configurations.
module tb_parallel_to_serial_flow;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Instance 0: width 8, lane 1, LSB first
    logic       pv0, pr0, sv0, sl0, sr0, bz0;
    logic [7:0] pd0;
    logic [0:0] sd0;
    // Instance 1: width 8, lane 2, MSB first
    logic       pv1, pr1, sv1, sl1, sr1, bz1;
    logic [7:0] pd1;
    logic [1:0] sd1;
    // Instances 2/3: width 12, lane 4, LSB / MSB first
    logic        pvR[2], prR[2], svR[2], slR[2], srR[2], bzR[2];
    logic [11:0] pdR[2];
    logic [3:0]  sdR[2];

    parallel_to_serial_flow #(.width(8), .lane(1), .msb_first(0)) u0 (
        .clk(clk), .rst(rst), .parallel_valid(pv0), .parallel_data(pd0), .parallel_ready(pr0),
        .serial_valid(sv0), .serial_data(sd0), .serial_last(sl0), .serial_ready(sr0), .busy(bz0));
    parallel_to_serial_flow #(.width(8), .lane(2), .msb_first(1)) u1 (
        .clk(clk), .rst(rst), .parallel_valid(pv1), .parallel_data(pd1), .parallel_ready(pr1),
        .serial_valid(sv1), .serial_data(sd1), .serial_last(sl1), .serial_ready(sr1), .busy(bz1));
    parallel_to_serial_flow #(.width(12), .lane(4), .msb_first(0)) u2 (
        .clk(clk), .rst(rst), .parallel_valid(pvR[0]), .parallel_data(pdR[0]), .parallel_ready(prR[0]),
        .serial_valid(svR[0]), .serial_data(sdR[0]), .serial_last(slR[0]), .serial_ready(srR[0]), .busy(bzR[0]));
    parallel_to_serial_flow #(.width(12), .lane(4), .msb_first(1)) u3 (
        .clk(clk), .rst(rst), .parallel_valid(pvR[1]), .parallel_data(pdR[1]), .parallel_ready(prR[1]),
        .serial_valid(svR[1]), .serial_data(sdR[1]), .serial_last(slR[1]), .serial_ready(srR[1]), .busy(bzR[1]));

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Beat k of a word: lane slice k counted from the LSB end, or from the MSB end.
    function automatic logic [31:0] exp_beat(input logic [31:0] word, input int w, input int l,
                                             input int msb, input int k);
        int idx;
        idx = (msb != 0) ? (w / l - 1 - k) : k;
        return (word >> (idx * l)) & ((32'd1 << l) - 32'd1);
    endfunction

    logic [11:0] words [2][1000];
    int          sent [2];
    int          done [2];
    int          beat [2];
    logic [11:0] acc [2];
    logic        stall_prev [2];
    logic [3:0]  prev_sd [2];
    logic        prev_sl [2];

    initial begin
        rst = 1'b1;
        pv0 = 0; pd0 = '0; sr0 = 0;
        pv1 = 0; pd1 = '0; sr1 = 0;
        for (int i = 0; i < 2; i++) begin
            pvR[i] = 0; pdR[i] = '0; srR[i] = 0;
            sent[i] = 0; done[i] = 0; beat[i] = 0; acc[i] = '0;
            stall_prev[i] = 0; prev_sd[i] = '0; prev_sl[i] = 0;
        end

        // Reset state
        tick(); tick();
        #1;
        chk("rst_busy", 32'(bz0), 32'd0);
        chk("rst_valid", 32'(sv0), 32'd0);
        chk("rst_last", 32'(sl0), 32'd0);
        chk("rst_data", 32'(sd0), 32'd0);
        chk("rst_ready", 32'(pr0), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_ready", 32'(pr0), 32'd1);

        // 8'hA5, lane 1, LSB first
        pv0 = 1; pd0 = 8'hA5; sr0 = 1;
        #1;
        chk("a5_ready", 32'(pr0), 32'd1);
        tick();
        pv0 = 0; pd0 = 8'($urandom);
        for (int k = 0; k < 8; k++) begin
            if (k == 4) pd0 = 8'($urandom);
            #1;
            chk("a5_valid", 32'(sv0), 32'd1);
            chk("a5_data", 32'(sd0), exp_beat(32'h A5, 8, 1, 0, k));
            chk("a5_last", 32'(sl0), 32'(k == 7));
            chk("a5_busy", 32'(bz0), 32'd1);
            tick();
        end
        #1;
        chk("a5_idle_valid", 32'(sv0), 32'd0);
        chk("a5_idle_busy", 32'(bz0), 32'd0);
        chk("a5_idle_data", 32'(sd0), 32'd0);

        // 8'hB4, lane 2, MSB first
        pv1 = 1; pd1 = 8'hB4; sr1 = 1;
        tick();
        pv1 = 0;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("b4_valid", 32'(sv1), 32'd1);
            chk("b4_data", 32'(sd1), exp_beat(32'hB4, 8, 2, 1, k));
            chk("b4_last", 32'(sl1), 32'(k == 3));
            tick();
        end
        #1;
        chk("b4_idle_valid", 32'(sv1), 32'd0);

        // Back-to-back FF then 00
        pv0 = 1; pd0 = 8'hFF; sr0 = 1;
        tick();
        pd0 = 8'h00;
        for (int k = 0; k < 16; k++) begin
            if (k == 15) pv0 = 0;
            #1;
            chk("b2b_valid", 32'(sv0), 32'd1);
            chk("b2b_data", 32'(sd0), 32'(k < 8));
            chk("b2b_last", 32'(sl0), 32'(k == 7 || k == 15));
            chk("b2b_ready", 32'(pr0), 32'(k == 7 || k == 15));
            tick();
        end
        #1;
        chk("b2b_idle_valid", 32'(sv0), 32'd0);

        // 8'h5A with a 3-cycle stall on beat 3
        pv0 = 1; pd0 = 8'h5A; sr0 = 1;
        tick();
        pv0 = 0;
        for (int k = 0; k < 8; k++) begin
            if (k == 2) begin
                for (int s = 0; s < 3; s++) begin
                    sr0 = 0;
                    #1;
                    chk("stall_valid", 32'(sv0), 32'd1);
                    chk("stall_data", 32'(sd0), 32'd0);
                    chk("stall_last", 32'(sl0), 32'd0);
                    tick();
                end
            end
            sr0 = 1;
            #1;
            chk("5a_valid", 32'(sv0), 32'd1);
            chk("5a_data", 32'(sd0), exp_beat(32'h5A, 8, 1, 0, k));
            chk("5a_last", 32'(sl0), 32'(k == 7));
            tick();
        end
        #1;
        chk("5a_idle_valid", 32'(sv0), 32'd0);

        // Reset pulse at beat 4 of 8'hC3, then 8'h01
        pv0 = 1; pd0 = 8'hC3; sr0 = 1;
        tick();
        pv0 = 0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("c3_data", 32'(sd0), exp_beat(32'hC3, 8, 1, 0, k));
            tick();
        end
        rst = 1;
        #1;
        chk("c3_b4_valid", 32'(sv0), 32'd1);
        chk("c3_b4_data", 32'(sd0), exp_beat(32'hC3, 8, 1, 0, 3));
        chk("c3_rst_ready", 32'(pr0), 32'd0);
        tick();
        rst = 0;
        #1;
        chk("c3_after_valid", 32'(sv0), 32'd0);
        chk("c3_after_busy", 32'(bz0), 32'd0);
        chk("c3_after_last", 32'(sl0), 32'd0);
        chk("c3_after_data", 32'(sd0), 32'd0);
        chk("c3_after_ready", 32'(pr0), 32'd1);
        tick();
        #1;
        chk("c3_quiet_valid", 32'(sv0), 32'd0);
        pv0 = 1; pd0 = 8'h01;
        tick();
        pv0 = 0;
        for (int k = 0; k < 8; k++) begin
            #1;
            chk("01_valid", 32'(sv0), 32'd1);
            chk("01_data", 32'(sd0), 32'(k == 0));
            chk("01_last", 32'(sl0), 32'(k == 7));
            tick();
        end

        // Random valid/ready, 1000 words per 12-bit instance
        for (int cyc = 0; cyc < 40000; cyc++) begin
            if (done[0] >= 1000 && done[1] >= 1000) break;
            for (int i = 0; i < 2; i++) begin
                pvR[i] = (sent[i] < 1000) && ($urandom_range(0, 3) != 0);
                pdR[i] = 12'($urandom);
                srR[i] = ($urandom_range(0, 3) != 0);
            end
            #1;
            for (int i = 0; i < 2; i++) begin
                if (stall_prev[i]) begin
                    chk("rnd_hold_valid", 32'(svR[i]), 32'd1);
                    chk("rnd_hold_data", 32'(sdR[i]), 32'(prev_sd[i]));
                    chk("rnd_hold_last", 32'(slR[i]), 32'(prev_sl[i]));
                end
                chk("rnd_busy", 32'(bzR[i]), 32'(svR[i]));
                if (svR[i]) begin
                    chk("rnd_last", 32'(slR[i]), 32'(beat[i] == 2));
                end else begin
                    chk("rnd_idle_data", 32'(sdR[i]), 32'd0);
                end
                chk("rnd_ready", 32'(prR[i]), 32'(!svR[i] || (srR[i] && beat[i] == 2)));
                if (svR[i] && srR[i]) begin
                    if (done[i] < sent[i]) begin
                        acc[i][((i == 1) ? (2 - beat[i]) : beat[i]) * 4 +: 4] = sdR[i];
                        if (beat[i] == 2) begin
                            chk("rnd_word", 32'(acc[i]), 32'(words[i][done[i]]));
                            done[i]++;
                            beat[i] = 0;
                        end else begin
                            beat[i]++;
                        end
                    end else begin
                        chk("rnd_spurious_beat", 32'(svR[i]), 32'd0);
                    end
                end
                if (prR[i] && pvR[i]) begin
                    words[i][sent[i]] = pdR[i];
                    sent[i]++;
                end
                stall_prev[i] = svR[i] && !srR[i];
                prev_sd[i] = sdR[i];
                prev_sl[i] = slR[i];
            end
            tick();
        end
        chk("rnd_done_lsb", 32'(done[0]), 32'd1000);
        chk("rnd_done_msb", 32'(done[1]), 32'd1000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
